// File: rtl/lcu_gen_pkg.sv
// lcu_gen_pkg: shared types and constants for the table-driven logic control unit.
//   arc_t      one transition arc {valid, mask, val, next, cmd}
//   arc_match  true when a valid arc's care bits agree with the condition inputs
// The arc field widths are fixed here; lcu_gen's N_IN/N_OUT/N_STATES must match.
package lcu_gen_pkg;

    localparam int LCU_N_IN     = 15;
    localparam int LCU_N_OUT    = 24;
    localparam int LCU_N_STATES = 22;
    localparam int LCU_N_ARCS   = 8;
    localparam int LCU_SW       = $clog2(LCU_N_STATES);

    localparam logic [LCU_SW-1:0] STATE_RESET = '0;

    typedef struct packed {
        logic                 valid;
        logic [LCU_N_IN-1:0]  mask;   // 1 = this input is a care bit
        logic [LCU_N_IN-1:0]  val;    // required value on the care bits
        logic [LCU_SW-1:0]    next;
        logic [LCU_N_OUT-1:0] cmd;
    } arc_t;

    // mask = 0 with valid = 1 matches unconditionally.
    function automatic logic arc_match(input arc_t a, input logic [LCU_N_IN-1:0] x);
        return a.valid && (((x ^ a.val) & a.mask) == '0);
    endfunction

endpackage

// File: rtl/lcu_gen_arc_table.sv
// lcu_gen_arc_table: N_STATES x N_ARCS arc storage with one write port and a
// read port returning every arc of one state.
//   clk, rst     clock, async active-low reset (clears valid bits only)
//   we           write strobe (caller has already range-checked the write)
//   wr_state     state row to write
//   wr_idx       arc slot within the row
//   wr_arc       arc contents
//   rd_state     state row to read; out-of-range rows read as all-invalid
//   rd_arcs      arcs of rd_state, index 0 = highest priority
module lcu_gen_arc_table
    import lcu_gen_pkg::*;
#(
    parameter int  N_STATES = LCU_N_STATES,
    parameter int  N_ARCS   = LCU_N_ARCS,
    localparam int SW       = $clog2(N_STATES),
    localparam int AW       = $clog2(N_ARCS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [SW-1:0]           wr_state,
    input  logic [AW-1:0]           wr_idx,
    input  arc_t                    wr_arc,
    input  logic [SW-1:0]           rd_state,
    output arc_t [N_ARCS-1:0]       rd_arcs
);

    localparam logic [SW:0] STATE_LIMIT = (SW+1)'(N_STATES);

    logic                 valid_q [N_STATES][N_ARCS];
    logic [LCU_N_IN-1:0]  mask_q  [N_STATES][N_ARCS];
    logic [LCU_N_IN-1:0]  val_q   [N_STATES][N_ARCS];
    logic [LCU_SW-1:0]    next_q  [N_STATES][N_ARCS];
    logic [LCU_N_OUT-1:0] cmd_q   [N_STATES][N_ARCS];

    // NOTE: only the valid bits need a reset value; an invalid arc's payload is
    // never observed, so the payload array stays reset-free and maps onto plain flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < N_STATES; s++)
                for (int a = 0; a < N_ARCS; a++)
                    valid_q[s][a] <= 1'b0;
        end else if (we) begin
            valid_q[wr_state][wr_idx] <= wr_arc.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mask_q[wr_state][wr_idx] <= wr_arc.mask;
            val_q[wr_state][wr_idx]  <= wr_arc.val;
            next_q[wr_state][wr_idx] <= wr_arc.next;
            cmd_q[wr_state][wr_idx]  <= wr_arc.cmd;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_arcs = '0;
        if ({1'b0, rd_state} < STATE_LIMIT) begin
            for (int a = 0; a < N_ARCS; a++) begin
                rd_arcs[a] = '{valid: valid_q[rd_state][a],
                               mask:  mask_q[rd_state][a],
                               val:   val_q[rd_state][a],
                               next:  next_q[rd_state][a],
                               cmd:   cmd_q[rd_state][a]};
            end
        end
    end

endmodule

// File: rtl/lcu_gen.sv
// lcu_gen: runtime-programmable Mealy control unit driven by an arc table.
//   clk, rst   clock, async active-low reset
//   en         step enable; 0 holds state and stall counter, forces y = 0
//   x          condition inputs
//   y          command outputs (combinational or registered per REG_OUT)
//   state      present state
//   cfg_*      arc write port; cfg_err pulses the cycle after a rejected write
//   wdog       pulses in the first cycle back in state 0 after a stall timeout
module lcu_gen
    import lcu_gen_pkg::*;
#(
    parameter int  N_IN     = LCU_N_IN,
    parameter int  N_OUT    = LCU_N_OUT,
    parameter int  N_STATES = LCU_N_STATES,
    parameter int  N_ARCS   = LCU_N_ARCS,
    parameter int  REG_OUT  = 0,
    parameter int  WDOG_W   = 8,
    localparam int SW       = $clog2(N_STATES),
    localparam int AW       = $clog2(N_ARCS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_IN-1:0]  x,
    output logic [N_OUT-1:0] y,
    output logic [SW-1:0]    state,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_state,
    input  logic [AW-1:0]    cfg_arc,
    input  logic             cfg_valid,
    input  logic [N_IN-1:0]  cfg_mask,
    input  logic [N_IN-1:0]  cfg_val,
    input  logic [SW-1:0]    cfg_next,
    input  logic [N_OUT-1:0] cfg_cmd,
    output logic             cfg_err,
    output logic             wdog
);

    localparam logic [SW:0] STATE_LIMIT = (SW+1)'(N_STATES);
    // Keep a 1-bit counter when the watchdog is disabled so the logic stays legal.
    localparam int CW = (WDOG_W > 0) ? WDOG_W : 1;

    logic [SW-1:0]      state_q, state_d;
    logic [CW-1:0]      stall_q, stall_d;
    logic               timeout;
    logic               state_ok, cfg_ok, tbl_we;
    arc_t [N_ARCS-1:0]  cur_arcs;
    arc_t               wr_arc, fired;
    logic               hit;
    logic [N_OUT-1:0]   cmd;

    assign state_ok = {1'b0, state_q}   < STATE_LIMIT;
    assign cfg_ok   = ({1'b0, cfg_state} < STATE_LIMIT) && ({1'b0, cfg_next} < STATE_LIMIT);
    assign tbl_we   = cfg_we && cfg_ok;
    assign wr_arc   = '{valid: cfg_valid, mask: cfg_mask, val: cfg_val,
                        next: cfg_next, cmd: cfg_cmd};
    assign state    = state_q;

    lcu_gen_arc_table #(
        .N_STATES (N_STATES),
        .N_ARCS   (N_ARCS)
    ) u_arc_table (
        .clk      (clk),
        .rst      (rst),
        .we       (tbl_we),
        .wr_state (cfg_state),
        .wr_idx   (cfg_arc),
        .wr_arc   (wr_arc),
        .rd_state (state_q),
        .rd_arcs  (cur_arcs)
    );

    // Priority encoder: scan from the lowest priority upward so arc 0 wins last.
    always_comb begin
        hit   = 1'b0;
        fired = '0;
        for (int i = N_ARCS - 1; i >= 0; i--) begin
            if (arc_match(cur_arcs[i], x)) begin
                hit   = 1'b1;
                fired = cur_arcs[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        cmd     = '0;
        timeout = 1'b0;
        if (en) begin
            if (hit) begin
                state_d = fired.next;
                cmd     = fired.cmd;
                stall_d = '0;
            end else if (WDOG_W == 0) begin
                // Without a watchdog, an upset state is pulled back directly.
                if (!state_ok)
                    state_d = STATE_RESET;
            end else if (stall_q == '1) begin
                state_d = STATE_RESET;
                stall_d = '0;
                timeout = 1'b1;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STATE_RESET;
            stall_q <= '0;
            wdog    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            wdog    <= timeout;
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [N_OUT-1:0] y_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) y_q <= '0;
            else      y_q <= cmd;
        end
        assign y = y_q;
    end else begin : g_comb_out
        assign y = cmd;
    end

endmodule

// File: tb/tb_lcu_gen.sv
// tb_lcu_gen: drives a combinational-output and a registered-output lcu_gen
// with the same directed stimulus and compares both against a table model.
// Naming: x1..x15 map to x[0..14], y1..y24 map to y[0..23].
module tb_lcu_gen;

    localparam int NS = 22;
    localparam int NA = 8;
    localparam logic [14:0] X15 = 15'h4000;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic [14:0] x = '0;
    logic        cfg_we = 1'b0, cfg_valid = 1'b0;
    logic [4:0]  cfg_state = '0, cfg_next = '0;
    logic [2:0]  cfg_arc = '0;
    logic [14:0] cfg_mask = '0, cfg_val = '0;
    logic [23:0] cfg_cmd = '0;

    logic [23:0] y0, y1;
    logic [4:0]  state0, state1;
    logic        err0, err1, wdog0, wdog1;

    always #5 clk = ~clk;

    lcu_gen #(.REG_OUT(0), .WDOG_W(8)) dut0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y0), .state(state0),
        .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_arc(cfg_arc), .cfg_valid(cfg_valid),
        .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_next(cfg_next), .cfg_cmd(cfg_cmd),
        .cfg_err(err0), .wdog(wdog0));

    lcu_gen #(.REG_OUT(1), .WDOG_W(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y1), .state(state1),
        .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_arc(cfg_arc), .cfg_valid(cfg_valid),
        .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_next(cfg_next), .cfg_cmd(cfg_cmd),
        .cfg_err(err1), .wdog(wdog1));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid [NS][NA];
    logic [14:0] m_mask  [NS][NA];
    logic [14:0] m_val   [NS][NA];
    int          m_next  [NS][NA];
    logic [23:0] m_cmd   [NS][NA];
    int          m_state, m_stall, m_h;
    logic [23:0] m_yreg;
    bit          m_err, m_wdog;

    function automatic int first_hit(input int s, input logic [14:0] xv);
        if (s >= NS) return -1;
        for (int a = 0; a < NA; a++)
            if (m_valid[s][a] && ((xv & m_mask[s][a]) == (m_val[s][a] & m_mask[s][a])))
                return a;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 0; m_stall = 0; m_yreg = '0; m_err = 0; m_wdog = 0;
            for (int s = 0; s < NS; s++)
                for (int a = 0; a < NA; a++)
                    m_valid[s][a] = 0;
        end else begin
            // evaluate with the table as it was before this edge's write
            m_h    = first_hit(m_state, x);
            m_wdog = 0;
            m_yreg = '0;
            if (en) begin
                if (m_h >= 0) begin
                    m_yreg  = m_cmd[m_state][m_h];
                    m_state = m_next[m_state][m_h];
                    m_stall = 0;
                end else if (m_stall == 255) begin
                    m_state = 0; m_stall = 0; m_wdog = 1;
                end else begin
                    m_stall = m_stall + 1;
                end
            end
            m_err = cfg_we && !(int'(cfg_state) < NS && int'(cfg_next) < NS);
            if (cfg_we && !m_err) begin
                m_valid[cfg_state][cfg_arc] = cfg_valid;
                m_mask[cfg_state][cfg_arc]  = cfg_mask;
                m_val[cfg_state][cfg_arc]   = cfg_val;
                m_next[cfg_state][cfg_arc]  = int'(cfg_next);
                m_cmd[cfg_state][cfg_arc]   = cfg_cmd;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int          c_h;
    logic [23:0] c_y;
    always @(negedge clk) begin
        c_h = first_hit(m_state, x);
        c_y = (rst && en && c_h >= 0) ? m_cmd[m_state][c_h] : '0;
        check("state_comb_dut", 32'(state0), 32'(m_state));
        check("state_reg_dut",  32'(state1), 32'(m_state));
        check("y_comb",         32'(y0),     32'(c_y));
        check("y_reg",          32'(y1),     32'(m_yreg));
        check("cfg_err",        32'(err0),   32'(m_err));
        check("cfg_err_reg",    32'(err1),   32'(m_err));
        check("wdog",           32'(wdog0),  32'(m_wdog));
        check("wdog_reg",       32'(wdog1),  32'(m_wdog));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_set(input int s, input int a, input logic v, input logic [14:0] mk,
                           input logic [14:0] vl, input int nx, input logic [23:0] cm);
        cfg_we    = 1'b1;
        cfg_state = 5'(s);
        cfg_arc   = 3'(a);
        cfg_valid = v;
        cfg_mask  = mk;
        cfg_val   = vl;
        cfg_next  = 5'(nx);
        cfg_cmd   = cm;
    endtask

    task automatic cfg_write(input int s, input int a, input logic v, input logic [14:0] mk,
                             input logic [14:0] vl, input int nx, input logic [23:0] cm);
        cfg_set(s, a, v, mk, vl, nx, cm);
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        int wd_edge;

        // reset state
        #12;
        check("rst_state", 32'(state0), 0);
        check("rst_y_reg", 32'(y1), 0);
        check("rst_wdog",  32'(wdog0), 0);

        // empty table, en=1: counter walks 0..255, the 256th no-match edge times out
        rst = 1'b1;
        en  = 1'b1;
        wd_edge = 0;
        for (int i = 1; i <= 300 && wd_edge == 0; i++) begin
            tick();
            if (wdog0) wd_edge = i;
        end
        check("wdog_edge", 32'(wd_edge), 256);
        check("wdog_state", 32'(state0), 0);

        // program table with the step disabled
        en = 1'b0;
        x  = '0;
        cfg_write(0, 0, 1'b1, X15, X15, 2, 24'h000006);   // x15 -> state 2, y2|y3
        cfg_write(0, 1, 1'b1, '0,  '0,  3, 24'h000001);   // else -> state 3, y1
        cfg_write(2, 0, 1'b1, '0,  '0,  0, 24'h800000);
        cfg_write(3, 0, 1'b1, '0,  '0,  0, 24'h400000);
        check("cfg_good_err", 32'(err0), 0);

        // priority: arc0 wins when x15=1
        x  = X15;
        en = 1'b1;
        #1;
        check("prio_y_comb", 32'(y0), 32'h000006);
        check("prio_y_reg_pre", 32'(y1), 0);
        tick();
        check("prio_state", 32'(state0), 2);
        check("regout_y", 32'(y1), 32'h000006);
        check("regout_state", 32'(state1), 2);
        x = '0;
        #1;
        check("s2_y_comb", 32'(y0), 32'h800000);
        tick();
        check("s2_back", 32'(state0), 0);
        #1;
        check("arc1_y_comb", 32'(y0), 32'h000001);
        tick();
        check("arc1_state", 32'(state0), 3);
        check("arc1_y_reg", 32'(y1), 32'h000001);
        tick();

        // en=0 while the arc matches
        en = 1'b0;
        x  = X15;
        #1;
        check("en0_y", 32'(y0), 0);
        tick();
        check("en0_state", 32'(state0), 0);
        check("en0_y_reg", 32'(y1), 0);

        // rejected and accepted writes
        cfg_write(0, 0, 1'b1, '0, '0, 22, 24'hABCDEF);
        check("err_next", 32'(err0), 1);
        check("err_next_reg", 32'(err1), 1);
        cfg_write(22, 0, 1'b1, '0, '0, 0, 24'h000005);
        check("err_state", 32'(err0), 1);
        cfg_write(5, 0, 1'b1, '0, '0, 0, 24'h000005);
        check("ok_state5", 32'(err0), 0);

        // rejected write left arc0 of state 0 intact
        en = 1'b1;
        #1;
        check("unchanged_y", 32'(y0), 32'h000006);
        tick();
        check("unchanged_state", 32'(state0), 2);
        tick();

        // rewrite arc0 of state 0 in the cycle it fires
        cfg_set(0, 0, 1'b1, X15, X15, 3, 24'h000010);
        #1;
        check("simul_y_old", 32'(y0), 32'h000006);
        tick();
        cfg_we = 1'b0;
        check("simul_state_old", 32'(state0), 2);
        check("simul_yreg_old", 32'(y1), 32'h000006);
        tick();
        #1;
        check("simul_y_new", 32'(y0), 32'h000010);
        tick();
        check("simul_state_new", 32'(state0), 3);
        check("simul_yreg_new", 32'(y1), 32'h000010);
        en = 1'b0;
        tick();

        // asynchronous reset while clk is high and state is 3
        rst = 1'b0;
        #1;
        check("async_state", 32'(state0), 0);
        check("async_state_reg", 32'(state1), 0);
        check("async_y_reg", 32'(y1), 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
        en = 1'b1;
        x  = X15;
        #1;
        check("post_rst_y", 32'(y0), 0);
        tick();
        check("post_rst_state", 32'(state0), 0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
